// File: rtl/qpp_interleaver.sv
// qpp_interleaver: buffers one code block and streams systematic and QPP-interleaved bits,
// walking pi(k) = (F1*k + F2*k^2) mod K with two running mod-K adders instead of multipliers.
module qpp_interleaver #(
  parameter int K  = 40,
  parameter int F1 = 3,
  parameter int F2 = 10,
  parameter int IW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [K-1:0]  din,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          sys_out,
  output logic          int_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] idx,
  output logic          last
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [IW-1:0] G0  = IW'((F1 + F2) % K);
  localparam logic [IW-1:0] D2  = IW'((2 * F2) % K);
  localparam logic [IW-1:0] KM1 = IW'(K - 1);
  localparam logic [IW:0]   KW  = (IW+1)'(K);
  state_t        state_q, state_d;
  logic [K-1:0]  buf_q, buf_d, din_rev;
  logic [IW-1:0] k_q, k_d, pi_q, pi_d, g_q, g_d;
  // Operands are always < K, so one conditional subtract brings the sum back into range.
  function automatic logic [IW-1:0] add_mod(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [IW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= KW) ? IW'(s - KW) : IW'(s);
  endfunction
  // Bit-reversed buffer so that c_k lives at buffer index k.
  assign din_rev   = {<<{din}};
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == RUN);
  assign last      = out_valid && (k_q == KM1);
  assign idx       = k_q;
  assign sys_out   = buf_q[k_q];
  assign int_out   = buf_q[pi_q];
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    k_d     = k_q;
    pi_d    = pi_q;
    g_d     = g_q;
    if (in_ready && in_valid) begin
      state_d = RUN;
      buf_d   = din_rev;
      k_d     = '0;
      pi_d    = '0;
      g_d     = G0;
    end else if (out_valid && out_ready) begin
      state_d = last ? IDLE : RUN;
      k_d     = last ? '0 : k_q + 1'b1;
      pi_d    = add_mod(pi_q, g_q);
      g_d     = add_mod(g_q, D2);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      k_q     <= '0;
      pi_q    <= '0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      k_q     <= k_d;
      pi_q    <= pi_d;
      g_q     <= g_d;
    end
  end
endmodule

// File: tb/tb_qpp_interleaver.sv
// tb_qpp_interleaver: directed scenarios for the QPP interleaver with a closed-form pi model.
module tb_qpp_interleaver;
  localparam int K = 40;
  logic          clk = 0;
  logic          rst = 0;
  logic [K-1:0]  din = '0;
  logic          in_valid = 0;
  logic          in_ready;
  logic          sys_out, int_out, out_valid, last;
  logic          out_ready = 0;
  logic [5:0]    idx;
  int            checks = 0;
  int            failures = 0;
  logic [K-1:0]  obs_sys, obs_int, obs_last;
  logic          idx_ok;
  int            beats;

  qpp_interleaver #(.K(K), .F1(3), .F2(10), .IW(6)) dut (
    .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .sys_out(sys_out), .int_out(int_out), .out_valid(out_valid), .out_ready(out_ready),
    .idx(idx), .last(last)
  );

  always #5 clk = ~clk;

  function automatic logic [K-1:0] exp_sys(input logic [K-1:0] d);
    logic [K-1:0] v;
    for (int k = 0; k < K; k++) v[k] = d[K-1-k];
    return v;
  endfunction

  function automatic logic [K-1:0] exp_int(input logic [K-1:0] d);
    logic [K-1:0] v;
    int p;
    for (int k = 0; k < K; k++) begin
      p = (3*k + 10*k*k) % K;
      v[k] = d[K-1-p];
    end
    return v;
  endfunction

  // Offers one block with out_ready=1 and records every beat; din is scrambled during RUN.
  task automatic run_block(input logic [K-1:0] d);
    bit done;
    done = 0; beats = 0; idx_ok = 1;
    obs_sys = '0; obs_int = '0; obs_last = '0;
    @(negedge clk); din = d; in_valid = 1; out_ready = 1;
    @(negedge clk); in_valid = 0; din = ~d;
    for (int c = 0; c < 200 && !done; c++) begin
      if (out_valid) begin
        if (beats < K) begin
          obs_sys[beats] = sys_out; obs_int[beats] = int_out; obs_last[beats] = last;
          if (idx != 6'(beats)) idx_ok = 0;
        end
        beats++;
        if (last) done = 1;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 0;
    #12;
    checks++;
    if ({in_ready, out_valid, sys_out, int_out, idx, last} !== {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b sys=%b int=%b idx=%0d last=%b, need 1 0 0 0 0 0",
               in_ready, out_valid, sys_out, int_out, idx, last);
    end
    @(negedge clk); rst = 1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle: vld=%b rdy=%b, need 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_parity;
    run_block(40'h5555555555);
    checks++;
    if (beats != K) begin failures++; $display("FAIL parity_beats: got %0d need %0d", beats, K); end
    checks++;
    if (obs_sys !== 40'hAAAAAAAAAA) begin failures++; $display("FAIL parity_sys: got %h need aaaaaaaaaa", obs_sys); end
    checks++;
    if (obs_int !== 40'hAAAAAAAAAA) begin failures++; $display("FAIL parity_int: got %h need aaaaaaaaaa", obs_int); end
    checks++;
    if (obs_last !== 40'h8000000000) begin failures++; $display("FAIL parity_last: got %h need 8000000000", obs_last); end
    checks++;
    if (idx_ok !== 1'b1) begin failures++; $display("FAIL parity_idx: idx sequence got %b need 1", idx_ok); end
  endtask

  task automatic test_single13;
    run_block(40'h0004000000);
    checks++;
    if (obs_int !== 40'h0000000002) begin failures++; $display("FAIL c13_int: got %h need 0000000002", obs_int); end
    checks++;
    if (obs_sys !== 40'h0000002000) begin failures++; $display("FAIL c13_sys: got %h need 0000002000", obs_sys); end
  endtask

  task automatic test_single7;
    run_block(40'h0100000000);
    checks++;
    if (obs_int !== 40'h8000000000) begin failures++; $display("FAIL c7_int: got %h need 8000000000", obs_int); end
    checks++;
    if (obs_int !== obs_last) begin failures++; $display("FAIL c7_last: int %h last %h must coincide", obs_int, obs_last); end
    checks++;
    if (obs_sys !== 40'h0000000080) begin failures++; $display("FAIL c7_sys: got %h need 0000000080", obs_sys); end
  endtask

  task automatic test_pattern;
    logic [K-1:0] d;
    d = 40'hC3A596F01E;
    run_block(d);
    checks++;
    if (obs_sys !== exp_sys(d)) begin failures++; $display("FAIL pattern_sys: got %h need %h", obs_sys, exp_sys(d)); end
    checks++;
    if (obs_int !== exp_int(d)) begin failures++; $display("FAIL pattern_int: got %h need %h", obs_int, exp_int(d)); end
  endtask

  task automatic test_stall;
    logic [K-1:0] d;
    logic         prev_stall, ps, pi, pl, stable_ok;
    logic [5:0]   px;
    bit           done;
    d = 40'h9E3779B97F;
    done = 0; beats = 0; prev_stall = 0; stable_ok = 1;
    ps = 0; pi = 0; pl = 0; px = '0;
    obs_sys = '0; obs_int = '0;
    @(negedge clk); din = d; in_valid = 1; out_ready = 0;
    @(negedge clk); in_valid = 0; din = ~d;
    for (int c = 0; c < 600 && !done; c++) begin
      if (prev_stall && {out_valid, sys_out, int_out, idx, last} !== {1'b1, ps, pi, px, pl}) stable_ok = 0;
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        if (beats < K) begin obs_sys[beats] = sys_out; obs_int[beats] = int_out; end
        beats++;
        if (last) done = 1;
      end
      prev_stall = out_valid && !out_ready;
      ps = sys_out; pi = int_out; px = idx; pl = last;
      @(negedge clk);
    end
    out_ready = 1;
    checks++;
    if (beats != K) begin failures++; $display("FAIL stall_beats: got %0d need %0d", beats, K); end
    checks++;
    if (stable_ok !== 1'b1) begin failures++; $display("FAIL stall_stable: stability flag %b need 1", stable_ok); end
    checks++;
    if (obs_sys !== exp_sys(d)) begin failures++; $display("FAIL stall_sys: got %h need %h", obs_sys, exp_sys(d)); end
    checks++;
    if (obs_int !== exp_int(d)) begin failures++; $display("FAIL stall_int: got %h need %h", obs_int, exp_int(d)); end
  endtask

  task automatic test_reset_mid;
    bit hit;
    hit = 0;
    @(negedge clk); din = '1; in_valid = 1; out_ready = 1;
    @(negedge clk); in_valid = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (out_valid && idx == 6'd20) hit = 1;
      else @(negedge clk);
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL rstmid_reach: idx 20 reached %b need 1", hit); end
    rst = 0;
    #1;
    checks++;
    if ({out_valid, in_ready, sys_out, int_out, idx, last} !== {1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0}) begin
      failures++;
      $display("FAIL rstmid_async: got vld=%b rdy=%b sys=%b int=%b idx=%0d last=%b, need 0 1 0 0 0 0",
               out_valid, in_ready, sys_out, int_out, idx, last);
    end
    @(negedge clk); rst = 1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_residual: vld=%b need 0", out_valid); end
    run_block(40'h123456789A);
    checks++;
    if (beats != K) begin failures++; $display("FAIL rstmid_beats: got %0d need %0d", beats, K); end
    checks++;
    if (obs_int !== exp_int(40'h123456789A)) begin
      failures++; $display("FAIL rstmid_int: got %h need %h", obs_int, exp_int(40'h123456789A));
    end
    checks++;
    if (idx_ok !== 1'b1) begin failures++; $display("FAIL rstmid_idx: idx sequence got %b need 1", idx_ok); end
  endtask

  task automatic test_back_to_back;
    logic [K-1:0] d1, d2, s_v[2], i_v[2];
    int           nb[2];
    int           blk, idle_cnt;
    d1 = 40'hF0F0F0F0F0; d2 = 40'h0123456789;
    s_v[0] = '0; s_v[1] = '0; i_v[0] = '0; i_v[1] = '0; nb[0] = 0; nb[1] = 0;
    blk = 0; idle_cnt = 0;
    @(negedge clk); din = d1; in_valid = 1; out_ready = 1;
    for (int c = 0; c < 300 && blk < 2; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (idx < 6'd40) begin s_v[blk][idx] = sys_out; i_v[blk][idx] = int_out; end
        nb[blk]++;
        if (nb[blk] == 5) din = (blk == 0) ? d2 : ~d2;
        if (last) blk++;
      end else if (blk == 1) idle_cnt++;
    end
    in_valid = 0;
    checks++;
    if (idle_cnt != 1) begin failures++; $display("FAIL b2b_gap: idle cycles %0d need 1", idle_cnt); end
    checks++;
    if (nb[0] != K || nb[1] != K) begin failures++; $display("FAIL b2b_beats: got %0d,%0d need %0d", nb[0], nb[1], K); end
    checks++;
    if (s_v[0] !== exp_sys(d1) || i_v[0] !== exp_int(d1)) begin
      failures++; $display("FAIL b2b_blk0: sys %h int %h need %h %h", s_v[0], i_v[0], exp_sys(d1), exp_int(d1));
    end
    checks++;
    if (s_v[1] !== exp_sys(d2) || i_v[1] !== exp_int(d2)) begin
      failures++; $display("FAIL b2b_blk1: sys %h int %h need %h %h", s_v[1], i_v[1], exp_sys(d2), exp_int(d2));
    end
  endtask

  initial begin
    test_reset;
    test_parity;
    test_single13;
    test_single7;
    test_pattern;
    test_stall;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
